// File: rtl/fetch_pkg.sv
// Shared constants and payload types for the instruction fetch slice.
// Redirect select encodings match the pipeline controller's sel_pc output.
package fetch_pkg;

  localparam logic [1:0] SEL_PC_SEQ    = 2'b00;
  localparam logic [1:0] SEL_PC_RESET  = 2'b01;
  localparam logic [1:0] SEL_PC_BRANCH = 2'b10;
  localparam logic [1:0] SEL_PC_REG    = 2'b11;

  typedef logic [31:0] instr_word_t;

  typedef struct packed {
    instr_word_t instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // One outstanding imem read; epoch tags which redirect generation issued it.
  typedef struct packed {
    logic        valid;
    logic        epoch;
    logic [31:0] pc;
  } fetch_req_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries with a single-cycle flush.
// Flush wins over a same-cycle push or pop; head is read straight from storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem_reg [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;
  logic           do_push;
  logic           do_pop;

  // The fetch unit's credit scheme guarantees a push never finds the FIFO full.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_reg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_data;
      end
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (do_push) begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        end
        if (do_pop) begin
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
        count_reg <= count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited reads to a fixed-latency imem,
// tags them with a redirect epoch and streams matching returns out through fetch_fifo.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_AW    = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MEM_LAT    = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_pc,
  input  logic [1:0]                      sel_pc,
  input  logic [31:0]                     branch_target,
  input  logic [31:0]                     reg_target,
  output logic                            imem_rd_en,
  output logic [IMEM_AW-1:0]              imem_addr,
  input  logic [31:0]                     imem_rdata,
  output logic [31:0]                     instr_out,
  output logic [31:0]                     instr_pc,
  output logic                            instr_valid,
  input  logic                            instr_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + $clog2(MEM_LAT + 1) + 1;

  logic [31:0]   pc_reg;
  logic [31:0]   pc_next;
  logic [31:0]   redirect_pc;
  logic          epoch_reg;
  logic          run_reg;
  fetch_req_t    req_reg [MEM_LAT];
  fetch_req_t    req_in  [MEM_LAT];
  fetch_req_t    ret;
  logic [SW-1:0] inflight;
  logic [SW-1:0] credit_used;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  fetch_entry_t  push_data;
  fetch_entry_t  head;

  always_comb begin
    case (sel_pc)
      SEL_PC_RESET:  redirect_pc = RESET_PC;
      SEL_PC_BRANCH: redirect_pc = branch_target;
      SEL_PC_REG:    redirect_pc = reg_target;
      default:       redirect_pc = pc_reg;
    endcase
    redirect_pc = word_align(redirect_pc);
  end

  always_comb begin
    pc_next = pc_reg;
    if (load_pc) begin
      pc_next = redirect_pc;
    end else if (imem_rd_en) begin
      pc_next = pc_reg + 32'd4;
    end
  end

  // run_reg keeps the first request off the cycle in which rst_n is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= RESET_PC;
      epoch_reg <= 1'b0;
      run_reg   <= 1'b0;
    end else begin
      pc_reg  <= pc_next;
      run_reg <= 1'b1;
      if (load_pc) begin
        epoch_reg <= ~epoch_reg;
      end
    end
  end

  for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_req_pipe
    if (gi == 0) begin : g_head
      assign req_in[gi] = '{valid: imem_rd_en, epoch: epoch_reg, pc: pc_reg};
    end else begin : g_shift
      assign req_in[gi] = req_reg[gi-1];
    end
  end

  // Redirects also kill in-flight slots: two quick toggles could otherwise
  // make an old epoch bit match again when MEM_LAT is large.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        req_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MEM_LAT; i++) begin
        req_reg[i] <= req_in[i];
        if (load_pc) begin
          req_reg[i].valid <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      if (req_reg[i].valid && (req_reg[i].epoch == epoch_reg)) begin
        inflight = inflight + SW'(1);
      end
    end
  end

  // Every outstanding read owns a FIFO slot, so a return can always be pushed.
  assign credit_used = SW'(fifo_count) + inflight;
  assign imem_rd_en  = run_reg && !load_pc && (credit_used < SW'(FIFO_DEPTH));
  assign imem_addr   = pc_reg[IMEM_AW+1:2];

  assign ret       = req_reg[MEM_LAT-1];
  assign push      = ret.valid && (ret.epoch == epoch_reg);
  assign push_data = '{instr: imem_rdata, pc: ret.pc};

  assign instr_valid = !fifo_empty && !load_pc;
  assign pop         = instr_valid && instr_ready;
  assign instr_out   = head.instr;
  assign instr_pc    = head.pc;

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (load_pc),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a 2-cycle imem returning word = word address, plus a
// queue-based model of the fetch stream (pending reads, buffered words, redirect generation).
module tb_instr_fetch_unit;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_pc;
  logic [1:0]  sel_pc;
  logic [31:0] branch_target;
  logic [31:0] reg_target;
  logic        imem_rd_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_pc       (load_pc),
    .sel_pc        (sel_pc),
    .branch_target (branch_target),
    .reg_target    (reg_target),
    .imem_rd_en    (imem_rd_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .fifo_count    (fifo_count)
  );

  // Instruction memory: data for a request appears exactly LAT cycles later.
  logic [1:0] mem_v;
  logic [7:0] mem_a0;
  logic [7:0] mem_a1;
  always @(posedge clk) begin
    mem_v  <= {mem_v[0], imem_rd_en};
    mem_a0 <= imem_addr;
    mem_a1 <= mem_a0;
  end
  assign imem_rdata = (mem_v[1] === 1'b1) ? {24'h0, mem_a1} : 32'hDEAD_BEEF;

  // Reference model
  typedef struct {
    int          due;
    logic [31:0] pc;
    int          gen;
  } req_t;

  req_t        pend[$];
  logic [31:0] q_pc[$];
  logic [31:0] q_instr[$];
  logic [31:0] m_pc;
  int          m_gen;
  bit          m_run;
  int          cyc;

  logic        exp_rd;
  logic [7:0]  exp_addr;
  logic        exp_valid;
  logic [31:0] exp_pc;
  logic [31:0] exp_out;
  logic [2:0]  exp_count;

  task automatic model_reset();
    pend.delete();
    q_pc.delete();
    q_instr.delete();
    m_pc  = 32'h0;
    m_gen = 0;
    m_run = 1'b0;
  endtask

  task automatic predict();
    int live;
    live = 0;
    foreach (pend[i]) begin
      if (pend[i].gen == m_gen) live++;
    end
    exp_rd    = m_run && !load_pc && ((q_pc.size() + live) < 4);
    exp_addr  = m_pc[9:2];
    exp_valid = !load_pc && (q_pc.size() > 0);
    exp_pc    = (q_pc.size() > 0) ? q_pc[0] : 32'h0;
    exp_out   = (q_instr.size() > 0) ? q_instr[0] : 32'h0;
    exp_count = 3'(q_pc.size());
  endtask

  task automatic commit();
    req_t        r;
    logic [31:0] tgt;
    logic [31:0] dummy;
    if (exp_valid && instr_ready) begin
      dummy = q_pc.pop_front();
      dummy = q_instr.pop_front();
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      if (r.gen == m_gen && !load_pc) begin
        q_pc.push_back(r.pc);
        q_instr.push_back({24'h0, r.pc[9:2]});
      end
    end
    if (load_pc) begin
      case (sel_pc)
        2'b00:   tgt = m_pc;
        2'b01:   tgt = 32'h0;
        2'b10:   tgt = branch_target;
        default: tgt = reg_target;
      endcase
      q_pc.delete();
      q_instr.delete();
      m_gen++;
      m_pc = tgt & 32'hFFFF_FFFC;
    end else if (exp_rd) begin
      pend.push_back('{due: cyc + LAT, pc: m_pc, gen: m_gen});
      m_pc = m_pc + 32'd4;
    end
    m_run = 1'b1;
    cyc++;
  endtask

  // Drive one cycle's inputs just after the edge, then wait to the sampling point.
  task automatic drive(input logic ld, input logic [1:0] sel, input logic [31:0] tgt, input logic rdy);
    load_pc       = ld;
    sel_pc        = sel;
    branch_target = (sel == 2'b10) ? tgt : $urandom();
    reg_target    = (sel == 2'b11) ? tgt : $urandom();
    instr_ready   = rdy;
    predict();
    @(negedge clk);
  endtask

  task automatic advance();
    commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    total++; if (imem_rd_en !== 1'b0) begin bad++; $display("FAIL reset rd_en got=%b exp=0", imem_rd_en); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset valid got=%b exp=0", instr_valid); end
    total++; if (instr_out !== 32'h0) begin bad++; $display("FAIL reset instr_out got=%h exp=0", instr_out); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset instr_pc got=%h exp=0", instr_pc); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset count got=%0d exp=0", fifo_count); end
    model_reset();
    rst_n = 1'b1;
    $display("reset released at cycle %0d", cyc);
  endtask

  // Spec-timed stream from a fresh reset: request from cycle 1, data from cycle 4.
  task automatic test_stream(input string tag, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      drive(1'b0, 2'b00, 32'h0, 1'b1);
      total++; if (imem_rd_en !== (k >= 1)) begin bad++; $display("FAIL %s rd_en k=%0d got=%b exp=%b", tag, k, imem_rd_en, k >= 1); end
      if (k >= 1) begin
        total++; if (imem_addr !== 8'(k - 1)) begin bad++; $display("FAIL %s addr k=%0d got=%h exp=%h", tag, k, imem_addr, 8'(k - 1)); end
      end
      total++; if (instr_valid !== (k >= 4)) begin bad++; $display("FAIL %s valid k=%0d got=%b exp=%b", tag, k, instr_valid, k >= 4); end
      if (k >= 4) begin
        total++; if (instr_pc !== 32'(4 * (k - 4)) || instr_out !== 32'(k - 4)) begin
          bad++; $display("FAIL %s data k=%0d got pc=%h ins=%h exp pc=%h ins=%h", tag, k, instr_pc, instr_out, 32'(4 * (k - 4)), 32'(k - 4));
        end
      end
      $display("%s k=%0d rd=%b addr=%h valid=%b pc=%h ins=%h", tag, k, imem_rd_en, imem_addr, instr_valid, instr_pc, instr_out);
      advance();
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 2'b00, 32'h0, k >= 20);
      total++; if (imem_rd_en !== exp_rd) begin bad++; $display("FAIL stall rd_en k=%0d got=%b exp=%b", k, imem_rd_en, exp_rd); end
      total++; if (fifo_count !== exp_count) begin bad++; $display("FAIL stall count k=%0d got=%0d exp=%0d", k, fifo_count, exp_count); end
      total++; if (instr_valid !== exp_valid) begin bad++; $display("FAIL stall valid k=%0d got=%b exp=%b", k, instr_valid, exp_valid); end
      if (exp_valid) begin
        total++; if (instr_pc !== exp_pc || instr_out !== exp_out) begin
          bad++; $display("FAIL stall data k=%0d got pc=%h ins=%h exp pc=%h ins=%h", k, instr_pc, instr_out, exp_pc, exp_out);
        end
      end
      if (k == 19) begin
        total++; if (fifo_count !== 3'd4 || imem_rd_en !== 1'b0) begin
          bad++; $display("FAIL stall_full got count=%0d rd=%b exp count=4 rd=0", fifo_count, imem_rd_en);
        end
      end
      $display("stall k=%0d rdy=%b count=%0d rd=%b valid=%b pc=%h", k, instr_ready, fifo_count, imem_rd_en, instr_valid, instr_pc);
      advance();
    end
  endtask

  task automatic test_branch();
    int n;
    n = 0;
    while (q_pc.size() != 3 && n < 40) begin
      drive(1'b0, 2'b00, 32'h0, 1'b0);
      advance();
      n++;
    end
    drive(1'b1, 2'b10, 32'h100, 1'b1);
    total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL branch_setup count got=%0d exp=3 (waited %0d)", fifo_count, n); end
    total++; if (instr_valid !== 1'b0 || imem_rd_en !== 1'b0) begin
      bad++; $display("FAIL branch_T got valid=%b rd=%b exp valid=0 rd=0", instr_valid, imem_rd_en);
    end
    $display("branch T load target=100 count=%0d", fifo_count);
    advance();
    for (int j = 1; j <= 6; j++) begin
      drive(1'b0, 2'b00, 32'h0, 1'b1);
      total++; if (instr_valid !== (j >= 4)) begin bad++; $display("FAIL branch valid j=%0d got=%b exp=%b", j, instr_valid, j >= 4); end
      if (j == 1) begin
        total++; if (imem_rd_en !== 1'b1 || imem_addr !== 8'h40) begin
          bad++; $display("FAIL branch_issue got rd=%b addr=%h exp rd=1 addr=40", imem_rd_en, imem_addr);
        end
      end
      if (j >= 4) begin
        total++; if (instr_pc !== 32'h100 + 32'(4 * (j - 4)) || instr_out !== 32'(32'h40 + j - 4)) begin
          bad++; $display("FAIL branch data j=%0d got pc=%h ins=%h exp pc=%h ins=%h", j, instr_pc, instr_out, 32'h100 + 32'(4 * (j - 4)), 32'(32'h40 + j - 4));
        end
      end
      $display("branch j=%0d valid=%b pc=%h ins=%h", j, instr_valid, instr_pc, instr_out);
      advance();
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b10, 32'h40, 1'b1);
    advance();
    for (int j = 0; j <= 11; j++) begin
      if (j == 0) drive(1'b1, 2'b11, 32'h80, 1'b1);
      else        drive(1'b0, 2'b00, 32'h0, 1'b1);
      total++; if (instr_valid !== (j >= 4)) begin bad++; $display("FAIL b2b valid j=%0d got=%b exp=%b", j, instr_valid, j >= 4); end
      if (j == 4) begin
        total++; if (instr_pc !== 32'h80) begin bad++; $display("FAIL b2b first_pc got=%h exp=80", instr_pc); end
      end
      if (instr_valid === 1'b1) begin
        total++; if (instr_pc >= 32'h40 && instr_pc < 32'h80) begin bad++; $display("FAIL b2b stale j=%0d got pc=%h exp outside 40..7c", j, instr_pc); end
      end
      $display("b2b j=%0d valid=%b pc=%h", j, instr_valid, instr_pc);
      advance();
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 2'b11, 32'hFFFF_FFFE, 1'b1);
    advance();
    for (int j = 1; j <= 6; j++) begin
      drive(1'b0, 2'b00, 32'h0, 1'b1);
      if (j == 1) begin
        total++; if (imem_rd_en !== 1'b1 || imem_addr !== 8'hFF) begin bad++; $display("FAIL wrap_addr0 got rd=%b addr=%h exp rd=1 addr=ff", imem_rd_en, imem_addr); end
      end
      if (j == 2) begin
        total++; if (imem_rd_en !== 1'b1 || imem_addr !== 8'h00) begin bad++; $display("FAIL wrap_addr1 got rd=%b addr=%h exp rd=1 addr=00", imem_rd_en, imem_addr); end
      end
      if (j == 4) begin
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr_out !== 32'hFF) begin
          bad++; $display("FAIL wrap_head got v=%b pc=%h ins=%h exp v=1 pc=fffffffc ins=ff", instr_valid, instr_pc, instr_out);
        end
      end
      if (j == 5) begin
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_out !== 32'h0) begin
          bad++; $display("FAIL wrap_next got v=%b pc=%h ins=%h exp v=1 pc=0 ins=0", instr_valid, instr_pc, instr_out);
        end
      end
      $display("wrap j=%0d rd=%b addr=%h valid=%b pc=%h", j, imem_rd_en, imem_addr, instr_valid, instr_pc);
      advance();
    end
  endtask

  task automatic test_random();
    logic        ld;
    logic [1:0]  sel;
    logic [31:0] tgt;
    logic        rdy;
    for (int k = 0; k < 300; k++) begin
      ld  = ($urandom_range(0, 99) < 8);
      sel = 2'($urandom_range(0, 3));
      tgt = $urandom();
      rdy = ($urandom_range(0, 99) < 70);
      drive(ld, sel, tgt, rdy);
      total++; if (imem_rd_en !== exp_rd) begin bad++; $display("FAIL rnd rd_en k=%0d got=%b exp=%b", k, imem_rd_en, exp_rd); end
      total++; if (imem_addr !== exp_addr) begin bad++; $display("FAIL rnd addr k=%0d got=%h exp=%h", k, imem_addr, exp_addr); end
      total++; if (instr_valid !== exp_valid) begin bad++; $display("FAIL rnd valid k=%0d got=%b exp=%b", k, instr_valid, exp_valid); end
      total++; if (fifo_count !== exp_count) begin bad++; $display("FAIL rnd count k=%0d got=%0d exp=%0d", k, fifo_count, exp_count); end
      if (exp_valid) begin
        total++; if (instr_pc !== exp_pc || instr_out !== exp_out) begin
          bad++; $display("FAIL rnd data k=%0d got pc=%h ins=%h exp pc=%h ins=%h", k, instr_pc, instr_out, exp_pc, exp_out);
        end
      end
      $display("rnd k=%0d ld=%b sel=%0d rdy=%b rd=%b addr=%h v=%b pc=%h cnt=%0d", k, ld, sel, rdy, imem_rd_en, imem_addr, instr_valid, instr_pc, fifo_count);
      advance();
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 2'b00, 32'h0, 1'b0);
      advance();
    end
    drive(1'b0, 2'b00, 32'h0, 1'b0);
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL rstmid_full count got=%0d exp=4", fifo_count); end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (imem_rd_en !== 1'b0) begin bad++; $display("FAIL rstmid rd_en got=%b exp=0", imem_rd_en); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rstmid valid got=%b exp=0", instr_valid); end
    total++; if (instr_out !== 32'h0) begin bad++; $display("FAIL rstmid instr_out got=%h exp=0", instr_out); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rstmid instr_pc got=%h exp=0", instr_pc); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rstmid count got=%0d exp=0", fifo_count); end
    $display("rstmid asserted: rd=%b valid=%b count=%0d", imem_rd_en, instr_valid, fifo_count);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_stream("restart", 10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    model_reset();
    test_reset();
    test_stream("stream", 24);
    test_stall();
    test_branch();
    test_back_to_back();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
